// File: rtl/lsu_mem_ctrl.sv
// Pipelined load/store unit sitting between EX and WB.
// Registers the writeback fields. Memory instructions are issued on a
// req/gnt/rvalid data port with byte enables and lane-replicated store data.
// Load data is sign- or zero-extended. The LSU stalls EX while a memory
// transaction is outstanding.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   lsu_valid/lsu_ready        EX handshake; ready is high only in IDLE
//   lsu_is_load/is_store       memory op kind; funct3 selects size and sign
//   lsu_addr, lsu_store_data   effective address and rs2
//   lsu_reg_wdata, wr_reg_*    non-memory result and writeback target
//   lsu_pc, lsu_inst           carried through to WB
//   mem_*                      data-memory request/response port
//   lsu_*_o                    WB fields; lsu_valid_o is a 1-cycle pulse
//   lsu_exc_o                  00 none, 01 misaligned, 10 bus timeout,
//                              11 illegal funct3
module lsu_mem_ctrl #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              lsu_is_load,
   input  logic              lsu_is_store,
   input  logic [2:0]        lsu_funct3,
   input  logic [31:0]       lsu_addr,
   input  logic [31:0]       lsu_store_data,
   input  logic [31:0]       lsu_reg_wdata,
   input  logic              lsu_wr_reg_en,
   input  logic [4:0]        lsu_wr_reg_addr,
   input  logic [31:0]       lsu_pc,
   input  logic [31:0]       lsu_inst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              lsu_valid_o,
   output logic [31:0]       lsu_reg_wdata_o,
   output logic              lsu_wr_reg_en_o,
   output logic [4:0]        lsu_wr_reg_addr_o,
   output logic [31:0]       lsu_pc_o,
   output logic [31:0]       lsu_inst_o,
   output logic [1:0]        lsu_exc_o
);

   localparam int unsigned      CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic               req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [3:0]         be_q, be_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               vld_q, vld_d;
   logic [1:0]         exc_q, exc_d;
   logic [31:0]        rwd_q, rwd_d, pc_q, pc_d, inst_q, inst_d;
   logic               wen_q, wen_d, wen_pend_q, wen_pend_d;
   logic [4:0]         rd_q, rd_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         off_q, off_d;

   logic               f3_bad, misal, timeout_hit;
   logic [CNT_W-1:0]   cnt_inc;
   logic [3:0]         be_new;
   logic [31:0]        wdata_new, ld_ext;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;

   // Request-side decode of the instruction presented in IDLE.
   always_comb begin
      if (lsu_is_store) f3_bad = lsu_funct3[2] || (lsu_funct3[1:0] == 2'b11);
      else              f3_bad = (lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11);
      misal = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
              ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
      case (lsu_funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << lsu_addr[1:0];
            wdata_new = {4{lsu_store_data[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << lsu_addr[1:0];
            wdata_new = {2{lsu_store_data[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = lsu_store_data;
         end
      endcase
   end

   // Response-side lane select and extension, driven by the captured access.
   always_comb begin
      byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_ext = {24'h0, byte_sel};
         3'b101:  ld_ext = {16'h0, half_sel};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Saturating counter; >= keeps the abort reachable if gnt lands on the
   // same cycle the limit is hit and the count moves past TO_VAL in WAIT.
   assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc >= TO_VAL);

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      vld_d      = 1'b0;
      exc_d      = 2'b00;
      rwd_d      = rwd_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      wen_d      = wen_q;
      wen_pend_d = wen_pend_q;
      rd_d       = rd_q;
      f3_d       = f3_q;
      off_d      = off_q;
      case (state_q)
         S_IDLE: begin
            if (lsu_valid) begin
               pc_d   = lsu_pc;
               inst_d = lsu_inst;
               rd_d   = lsu_wr_reg_addr;
               if (!lsu_is_load && !lsu_is_store) begin
                  vld_d = 1'b1;
                  rwd_d = lsu_reg_wdata;
                  wen_d = lsu_wr_reg_en;
               end else if (f3_bad || misal) begin
                  vld_d = 1'b1;
                  exc_d = f3_bad ? 2'b11 : 2'b01;
                  rwd_d = '0;
                  wen_d = 1'b0;
               end else begin
                  state_d    = S_REQ;
                  req_d      = 1'b1;
                  we_d       = lsu_is_store;
                  addr_d     = {lsu_addr[ADDR_W-1:2], 2'b00};
                  be_d       = be_new;
                  wdata_d    = wdata_new;
                  cnt_d      = '0;
                  wen_pend_d = lsu_is_load && lsu_wr_reg_en;
                  f3_d       = lsu_funct3;
                  off_d      = lsu_addr[1:0];
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_inc;
            if (mem_gnt) begin
               req_d   = 1'b0;
               state_d = S_WAIT;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               state_d = S_RESP;
               vld_d   = 1'b1;
               exc_d   = 2'b10;
               rwd_d   = '0;
               wen_d   = 1'b0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (mem_rvalid) begin
               state_d = S_RESP;
               vld_d   = 1'b1;
               rwd_d   = we_q ? '0 : ld_ext;
               wen_d   = wen_pend_q;
            end else if (timeout_hit) begin
               state_d = S_RESP;
               vld_d   = 1'b1;
               exc_d   = 2'b10;
               rwd_d   = '0;
               wen_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         vld_q      <= 1'b0;
         exc_q      <= 2'b00;
         rwd_q      <= '0;
         pc_q       <= '0;
         inst_q     <= '0;
         wen_q      <= 1'b0;
         wen_pend_q <= 1'b0;
         rd_q       <= '0;
         f3_q       <= '0;
         off_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
         exc_q      <= exc_d;
         rwd_q      <= rwd_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         wen_q      <= wen_d;
         wen_pend_q <= wen_pend_d;
         rd_q       <= rd_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
      end
   end

   assign lsu_ready         = (state_q == S_IDLE);
   assign mem_req           = req_q;
   assign mem_we            = we_q;
   assign mem_addr          = addr_q;
   assign mem_be            = be_q;
   assign mem_wdata         = wdata_q;
   assign lsu_valid_o       = vld_q;
   assign lsu_exc_o         = exc_q;
   assign lsu_reg_wdata_o   = rwd_q;
   assign lsu_wr_reg_en_o   = wen_q;
   assign lsu_wr_reg_addr_o = rd_q;
   assign lsu_pc_o          = pc_q;
   assign lsu_inst_o        = inst_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl. It runs directed cases, then random
// instructions. Expected values come from an arithmetic model of the access
// rules: size in bytes, lane = addr mod 4, and data is shifted and masked.
module tb_lsu_mem_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid, lsu_ready, lsu_is_load, lsu_is_store;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr, lsu_store_data, lsu_reg_wdata, lsu_pc, lsu_inst;
   logic        lsu_wr_reg_en;
   logic [4:0]  lsu_wr_reg_addr;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        lsu_valid_o, lsu_wr_reg_en_o;
   logic [31:0] lsu_reg_wdata_o, lsu_pc_o, lsu_inst_o;
   logic [4:0]  lsu_wr_reg_addr_o;
   logic [1:0]  lsu_exc_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .lsu_is_load(lsu_is_load), .lsu_is_store(lsu_is_store),
      .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr),
      .lsu_store_data(lsu_store_data), .lsu_reg_wdata(lsu_reg_wdata),
      .lsu_wr_reg_en(lsu_wr_reg_en), .lsu_wr_reg_addr(lsu_wr_reg_addr),
      .lsu_pc(lsu_pc), .lsu_inst(lsu_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .lsu_valid_o(lsu_valid_o), .lsu_reg_wdata_o(lsu_reg_wdata_o),
      .lsu_wr_reg_en_o(lsu_wr_reg_en_o), .lsu_wr_reg_addr_o(lsu_wr_reg_addr_o),
      .lsu_pc_o(lsu_pc_o), .lsu_inst_o(lsu_inst_o), .lsu_exc_o(lsu_exc_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Access rules: size 1/2/4 bytes, lanes from addr mod 4, store data byte
   // i comes from source byte (i mod size), load data shifted down and masked.
   function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rdat,
                                 output logic [1:0] exc, output logic [3:0] be,
                                 output logic [31:0] wd, output logic [31:0] res);
      int unsigned size, off;
      logic [31:0] v, mask;
      off = a % 4;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      be = '0; wd = '0; res = '0;
      if (size == 0 || (!ld && f3[2])) exc = 2'b11;
      else if ((a % size) != 0)        exc = 2'b01;
      else                             exc = 2'b00;
      if (exc == 2'b00) begin
         be = 4'(((1 << size) - 1) << off);
         for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 1);
         v = (rdat >> (8*off)) & mask;
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
         res = v;
      end
   endfunction

   // Called at a negedge with the DUT idle. gd = REQ cycles before gnt
   // (-1: never), rdly = cycles gnt->rvalid (-1: never), spur = rvalid in REQ.
   task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                        input bit wen, input logic [4:0] rd, input logic [31:0] rdat,
                        input int gd, input int rdly, input bit spur);
      logic [1:0]  e_exc;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_res, pc, inst;
      int gnt_at, rv_at, done_at;
      bit to, exp_req;
      pc = $urandom; inst = $urandom;
      model(ld, f3, a, sd, rdat, e_exc, e_be, e_wd, e_res);
      chk("ready_before_issue", lsu_ready, 1);
      lsu_valid = 1; lsu_is_load = ld; lsu_is_store = st; lsu_funct3 = f3;
      lsu_addr = a; lsu_store_data = sd; lsu_reg_wdata = alu; lsu_wr_reg_en = wen;
      lsu_wr_reg_addr = rd; lsu_pc = pc; lsu_inst = inst;
      @(negedge clk);
      lsu_valid = 0; lsu_reg_wdata = $urandom; lsu_pc = $urandom;
      if ((!ld && !st) || e_exc != 2'b00) begin
         chk("quick_valid", lsu_valid_o, 1);
         chk("quick_exc", lsu_exc_o, (!ld && !st) ? 2'b00 : e_exc);
         chk("quick_wen", lsu_wr_reg_en_o, (!ld && !st) ? wen : 1'b0);
         if (!ld && !st) chk("quick_wdata", lsu_reg_wdata_o, alu);
         chk("quick_rd", lsu_wr_reg_addr_o, rd);
         chk("quick_pc", lsu_pc_o, pc);
         chk("quick_inst", lsu_inst_o, inst);
         chk("quick_ready", lsu_ready, 1);
         chk("quick_no_req", mem_req, 0);
      end else begin
         to      = (gd < 0) || (rdly < 0);
         gnt_at  = (gd < 0) ? -1 : 1 + gd;
         rv_at   = to ? -1 : 1 + gd + rdly;
         done_at = to ? 1 + TO : rv_at + 1;
         for (int cyc = 1; cyc <= done_at; cyc++) begin
            if (cyc < done_at) begin
               exp_req = (gd < 0) || (cyc <= gnt_at);
               chk("mem_req", mem_req, exp_req);
               chk("busy_ready", lsu_ready, 0);
               chk("busy_valid", lsu_valid_o, 0);
               chk("busy_exc", lsu_exc_o, 0);
               if (exp_req) begin
                  chk("mem_we", mem_we, st);
                  chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                  chk("mem_be", mem_be, e_be);
                  if (st) chk("mem_wdata", mem_wdata, e_wd);
               end
               mem_gnt    = (cyc == gnt_at);
               mem_rvalid = (cyc == rv_at) || (spur && (gd < 0 || cyc < gnt_at));
               mem_rdata  = (cyc == rv_at) ? rdat : $urandom;
               @(negedge clk);
            end else begin
               mem_gnt = 0; mem_rvalid = 0;
               chk("resp_valid", lsu_valid_o, 1);
               chk("resp_exc", lsu_exc_o, to ? 2'b10 : 2'b00);
               chk("resp_wen", lsu_wr_reg_en_o, (to || st) ? 1'b0 : wen);
               if (!to) chk("resp_wdata", lsu_reg_wdata_o, st ? 32'h0 : e_res);
               chk("resp_rd", lsu_wr_reg_addr_o, rd);
               chk("resp_pc", lsu_pc_o, pc);
               chk("resp_inst", lsu_inst_o, inst);
               chk("resp_no_req", mem_req, 0);
            end
         end
      end
      mem_gnt = 0; mem_rvalid = 0;
      @(negedge clk);
      chk("after_valid", lsu_valid_o, 0);
      chk("after_exc", lsu_exc_o, 0);
      chk("after_ready", lsu_ready, 1);
   endtask

   initial begin
      logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0] f3;
      logic [31:0] a;
      int kind;
      bit ld;
      rst_n = 0; lsu_valid = 0; lsu_is_load = 0; lsu_is_store = 0; lsu_funct3 = 0;
      lsu_addr = 0; lsu_store_data = 0; lsu_reg_wdata = 0; lsu_wr_reg_en = 0;
      lsu_wr_reg_addr = 0; lsu_pc = 0; lsu_inst = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", lsu_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_valid", lsu_valid_o, 0);
      chk("rst_exc", lsu_exc_o, 0);
      chk("rst_wdata_o", lsu_reg_wdata_o, 0);
      rst_n = 1;
      @(negedge clk);

      // ADD-type, LB, LHU, SB, misaligned LW, illegal SW funct3
      issue(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 1, 5'd5, 32'h0, 0, 1, 0);
      issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 1, 5'd7, 32'h80FF_FF01, 2, 3, 0);
      issue(1, 0, 3'b101, 32'h102, 32'h0, 32'h0, 1, 5'd9, 32'h8001_0000, 0, 1, 0);
      issue(0, 1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 1, 5'd3, 32'h0, 1, 2, 0);
      issue(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 5'd4, 32'h0, 0, 1, 0);
      issue(0, 1, 3'b011, 32'h100, 32'h0, 32'h0, 1, 5'd4, 32'h0, 0, 1, 0);
      // timeout with no gnt, timeout waiting for rvalid, rvalid ignored in REQ
      issue(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 1, 5'd6, 32'h0, -1, 1, 0);
      issue(0, 1, 3'b010, 32'h304, 32'h5555_AAAA, 32'h0, 1, 5'd6, 32'h0, 2, -1, 0);
      issue(1, 0, 3'b001, 32'h306, 32'h0, 32'h0, 1, 5'd8, 32'h7FFF_1234, 2, 1, 1);

      // reset while in REQ
      lsu_valid = 1; lsu_is_load = 1; lsu_is_store = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h400;
      @(negedge clk);
      lsu_valid = 0;
      chk("rreq_req", mem_req, 1);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("rreq_req_drop", mem_req, 0);
      chk("rreq_valid", lsu_valid_o, 0);
      chk("rreq_ready", lsu_ready, 1);

      // reset while in WAIT, then a late rvalid that must be ignored
      lsu_valid = 1;
      @(negedge clk);
      lsu_valid = 0; mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0;
      chk("rwait_req", mem_req, 0);
      chk("rwait_ready", lsu_ready, 0);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("rwait_valid", lsu_valid_o, 0);
      chk("rwait_ready_after", lsu_ready, 1);
      mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_rvalid = 0;
      chk("late_rvalid_valid", lsu_valid_o, 0);
      chk("late_rvalid_req", mem_req, 0);
      @(negedge clk);
      chk("late_rvalid_valid2", lsu_valid_o, 0);

      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         ld   = (kind < 6);
         f3   = ld ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         if (kind == 9) f3 = 3'($urandom);
         a = $urandom;
         if (kind != 9) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         if (kind < 2)
            issue(0, 0, f3, a, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, 0, 1, 0);
         else
            issue(ld, !ld, f3, a, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
